rpn_stack_ctrl: RTL
===================

# rpn_stack_ctrl

Sequencer for the RPN calculator's operand stack. Accepts push and binary-operation requests from the front-panel decode logic and drives the single-port synchronous stack RAM (registered address/write inputs, 1-cycle read latency). It reads the two top operands, computes the result, and writes it back in place. It tracks stack occupancy and flags overflow, underflow and illegal operations through an ERROR state.

## Interface
- DEPTH, 16: stack entries; power of two, ≥2
- AW, 4: address width, log2(DEPTH)
- CLOCK_50  in  1  system clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- enter  in  1  one-cycle request strobe (edge-detected upstream)
- is_op  in  1  0 = push din, 1 = binary operation
- op  in  2  00 add, 01 sub, 10 and, 11 mul (see Configuration)
- din  in  8  push value
- clr  in  1  one-cycle strobe; leaves ERROR
- ram_q  in  8  RAM read data
- ram_addr  out  AW  RAM address (combinational from state/count)
- ram_wdata  out  8  RAM write data
- ram_wren  out  1  RAM write enable
- sp  out  AW  top-of-stack index; 0 when empty
- count  out  AW+1  occupied entries, 0..DEPTH
- top  out  8  registered copy of top-of-stack value
- busy  out  1  high in any state other than IDLE/ERROR
- error  out  1  high in ERROR

## Operation
- States: IDLE, WRITE, RD_B, RD_A, CAP_A, WB, ERROR.
- IDLE, enter & !is_op: if count==DEPTH → ERROR (overflow). Otherwise → WRITE.
- WRITE: ram_addr=count[AW-1:0], ram_wdata=din (latched at enter), ram_wren=1. At the clock edge: count+1, top←din → IDLE.
- IDLE, enter & is_op: if count<2 → ERROR (underflow). If the op is illegal → ERROR. Otherwise → RD_B.
- RD_B: ram_addr=count-1 → RD_A.
- RD_A: ram_addr=count-2; capture b←ram_q → CAP_A.
- CAP_A: capture a←ram_q → WB.
- WB: ram_addr=count-2, ram_wdata=f(a,b), ram_wren=1. At the clock edge: count-1, top←f(a,b) → IDLE.
- Arithmetic is 8-bit modulo 256. Carry and borrow are discarded.
  - add: a+b
  - sub: a−b (a is the deeper operand)
  - and: a&b
  - mul: low byte of a×b
- sp = count-1 when count>0, else 0.
- ERROR:
  - Stack contents, count and top are unchanged from the value they held before the failed request.
  - enter is ignored.
  - clr → IDLE.
  - clr and enter in the same cycle: clr wins, enter is dropped.
- enter while busy is ignored, not queued. clr outside ERROR has no effect.
- ram_wren is 1 only in WRITE and WB.

## Timing
- Reset (async, immediate):
  - state=IDLE, count=0, top=0
  - ram_wren=0, ram_addr=0, ram_wdata=0
  - busy=0, error=0
  - RAM contents are not cleared.
- Reset mid-operation aborts it. No partial write occurs after rst_n falls.
- Push: enter sampled in cycle 0; WRITE in cycle 1; IDLE with updated count/top in cycle 2. 2-cycle latency; a new enter is accepted from cycle 2.
- Operation: enter in cycle 0; RD_B 1, RD_A 2, CAP_A 3, WB 4; IDLE in cycle 5. busy is high in cycles 1–4.
- Error detection: ERROR in cycle 1, no RAM access. ERROR → IDLE on the edge after the clr cycle.
- Full boundary: count==DEPTH still permits operations. Push at count==DEPTH-1 succeeds and writes address DEPTH-1.

## Configuration
- RPN_MUL_EN defined: op 11 = multiply, 8×8 with the low byte kept, single-cycle combinational.
- RPN_MUL_EN undefined: no multiplier is instantiated. op 11 is illegal, goes to ERROR and leaves the stack unchanged.

## Test plan
- Reset, push A9 → sp=0, count=1, mem[0]=A9, top=A9. Push 1B → sp=1, count=2, mem[1]=1B.
- From {A9,1B}, op add → after 5 cycles count=1, sp=0, mem[0]=C4, top=C4, busy high for exactly 4 cycles. Repeat with op sub on {10,30} → E0.
- Op with count=1 → error=1, count=1, top unchanged, ram_wren never high. Then clr+enter in the same cycle → IDLE and no push.
- 16 pushes of 00..0F, then a 17th push of FF → error=1, count=16, mem[15]=0F.
- RPN_MUL_EN defined: {12,10} mul → 20. Undefined: same stimulus → error=1, count=2.
- Assert rst_n low during WB of an add → ram_wren=0 immediately, count=0, state IDLE, mem[0] retains its pre-operation value.

Source files
------------

// File: rtl/rpn_stack_ctrl.sv
// rpn_stack_ctrl: RPN operand-stack sequencer driving a 1-cycle-latency single-port stack RAM.
// Define RPN_MUL_EN to enable op 11 (multiply); otherwise op 11 is rejected as illegal.
module rpn_stack_ctrl #(
   parameter int DEPTH = 16,
   parameter int AW = 4
) (
   input  logic          CLOCK_50,
   input  logic          rst_n,
   input  logic          enter,
   input  logic          is_op,
   input  logic [1:0]    op,
   input  logic [7:0]    din,
   input  logic          clr,
   input  logic [7:0]    ram_q,
   output logic [AW-1:0] ram_addr,
   output logic [7:0]    ram_wdata,
   output logic          ram_wren,
   output logic [AW-1:0] sp,
   output logic [AW:0]   count,
   output logic [7:0]    top,
   output logic          busy,
   output logic          error
);
   typedef enum logic [2:0] {IDLE, WRITE, RD_B, RD_A, CAP_A, WB, ERROR} state_t;
   localparam logic [AW:0] ONE = (AW+1)'(1);
   localparam logic [AW:0] TWO = (AW+1)'(2);
   localparam logic [AW:0] FULL = (AW+1)'(DEPTH);
   state_t state, next;
   logic [7:0] din_q, a, b, res, mul_res;
   logic [1:0] op_q;
   logic [AW-1:0] cm1, cm2;
   logic op_ok;
`ifdef RPN_MUL_EN
   assign mul_res = a * b;
   assign op_ok = 1'b1;
`else
   assign mul_res = '0;
   assign op_ok = (op != 2'b11);
`endif
   assign cm1 = AW'(count - ONE);
   assign cm2 = AW'(count - TWO);
   assign res = op_q == 2'b00 ? a + b : op_q == 2'b01 ? a - b : op_q == 2'b10 ? a & b : mul_res;
   assign ram_addr = state == WRITE ? count[AW-1:0] : state == RD_B ? cm1 :
                     (state == RD_A || state == WB) ? cm2 : '0;
   assign ram_wren = (state == WRITE) || (state == WB);
   assign ram_wdata = state == WRITE ? din_q : state == WB ? res : '0;
   assign sp = count == '0 ? '0 : cm1;
   assign busy = (state != IDLE) && (state != ERROR);
   assign error = state == ERROR;
   always_comb begin
      next = state;
      case (state)
         IDLE:    if (enter) next = !is_op ? (count == FULL ? ERROR : WRITE) :
                                    (count < TWO || !op_ok) ? ERROR : RD_B;
         WRITE:   next = IDLE;
         RD_B:    next = RD_A;
         RD_A:    next = CAP_A;
         CAP_A:   next = WB;
         WB:      next = IDLE;
         ERROR:   if (clr) next = IDLE;
         default: next = IDLE;
      endcase
   end
   always_ff @(posedge CLOCK_50 or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
         count <= '0;
         top <= '0;
         din_q <= '0;
         op_q <= '0;
         a <= '0;
         b <= '0;
      end else begin
         state <= next;
         if (state == IDLE && enter) begin
            din_q <= din;
            op_q <= op;
         end
         // RAM data lags the address by one cycle: b is the top entry, a the one beneath
         if (state == RD_A) b <= ram_q;
         if (state == CAP_A) a <= ram_q;
         if (state == WRITE) begin
            count <= count + ONE;
            top <= din_q;
         end
         if (state == WB) begin
            count <= count - ONE;
            top <= res;
         end
      end
   end
endmodule
